// File: rtl/rtf65002_muldiv_pkg.sv
// Shared definitions for the rtf65002 multiply/divide sequencer:
// op encodings, sequencer states and the default operand width.
package rtf65002_muldiv_pkg;

   localparam int unsigned WID_DEF = 32;

   localparam logic [1:0] OP_MULU = 2'd0;
   localparam logic [1:0] OP_MULS = 2'd1;
   localparam logic [1:0] OP_DIVU = 2'd2;
   localparam logic [1:0] OP_DIVS = 2'd3;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_MUL   = 3'd1,
      ST_DIV   = 3'd2,
      ST_FIXUP = 3'd3,
      ST_DONE  = 3'd4
   } state_e;

   function automatic logic op_is_div(input logic [1:0] o);
      return o[1];
   endfunction

   function automatic logic op_is_signed(input logic [1:0] o);
      return o[0];
   endfunction

endpackage

// File: rtl/rtf65002_divstep.sv
// One restoring-division step. The trial subtraction is done by the
// sequencer's shared adder: this block supplies its minuend and picks the result.
module rtf65002_divstep
   import rtf65002_muldiv_pkg::*;
#(
   parameter int unsigned WID = WID_DEF
) (
   input  logic [WID-1:0] rem_i,
   input  logic [WID-1:0] quo_i,
   input  logic [WID:0]   diff_i,
   output logic [WID:0]   shrem_o,
   output logic [WID-1:0] rem_o,
   output logic [WID-1:0] quo_o
);

   logic borrow;

   // rem < divisor holds between steps, so bit WID of the difference is the borrow
   assign shrem_o = {rem_i, quo_i[WID-1]};
   assign borrow  = diff_i[WID];
   assign rem_o   = borrow ? shrem_o[WID-1:0] : diff_i[WID-1:0];
   assign quo_o   = {quo_i[WID-2:0], ~borrow};

endmodule

// File: rtl/rtf65002_muldiv_seq.sv
// Radix-2 iterative multiply/divide sequencer for the rtf65002 core.
// Divider datapath is built only when RTF65002_MULDIV_DIV_EN is defined.
module rtf65002_muldiv_seq
   import rtf65002_muldiv_pkg::*;
#(
   parameter int unsigned WID = WID_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic [1:0]       op,
   input  logic [WID-1:0]   a,
   input  logic [WID-1:0]   b,
   output logic             busy,
   output logic             done,
   output logic [2*WID-1:0] prod,
   output logic [WID-1:0]   quo,
   output logic [WID-1:0]   rem,
   output logic             dbz
);

   localparam int unsigned CW = $clog2(WID);

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WID:0]     acc_q, acc_d;
   logic [WID-1:0]   lo_q, lo_d;
   logic [WID-1:0]   opd_q, opd_d;
   logic             neg_q, neg_d;
   logic             div_q, div_d;
   logic [2*WID-1:0] prod_q, prod_d;
   logic [WID-1:0]   quo_q, quo_d;
   logic [WID-1:0]   rem_q, rem_d;
   logic             dbz_q, dbz_d;

   logic             a_neg, b_neg;
   logic [WID-1:0]   a_abs, b_abs;
   logic [2*WID-1:0] mul_res;
   logic [WID:0]     add_a, add_b, sum;
   logic             sub;

`ifdef RTF65002_MULDIV_DIV_EN
   logic             rneg_q, rneg_d;
   logic             dz_q, dz_d;
   logic [WID:0]     shrem;
   logic [WID-1:0]   drem, dquo;

   rtf65002_divstep #(.WID(WID)) u_divstep (
      .rem_i   (acc_q[WID-1:0]),
      .quo_i   (lo_q),
      .diff_i  (sum),
      .shrem_o (shrem),
      .rem_o   (drem),
      .quo_o   (dquo)
   );
`endif

   always_comb begin
      a_neg   = op_is_signed(op) & a[WID-1];
      b_neg   = op_is_signed(op) & b[WID-1];
      a_abs   = a_neg ? -a : a;
      b_abs   = b_neg ? -b : b;
      mul_res = {acc_q[WID-1:0], lo_q};
   end

   // One WID+1 adder: acc + (mplr[0] ? mcand : 0) for MUL, shifted rem - divisor for DIV
   always_comb begin
      sub   = 1'b0;
      add_a = acc_q;
      add_b = lo_q[0] ? {1'b0, opd_q} : '0;
`ifdef RTF65002_MULDIV_DIV_EN
      if (state_q == ST_DIV) begin
         sub   = 1'b1;
         add_a = shrem;
         add_b = {1'b0, opd_q};
      end
`endif
      sum = add_a + (sub ? ~add_b : add_b) + {{WID{1'b0}}, sub};
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      lo_d    = lo_q;
      opd_d   = opd_q;
      neg_d   = neg_q;
      div_d   = div_q;
      prod_d  = prod_q;
      quo_d   = quo_q;
      rem_d   = rem_q;
      dbz_d   = dbz_q;
`ifdef RTF65002_MULDIV_DIV_EN
      rneg_d  = rneg_q;
      dz_d    = dz_q;
`endif
      if (abort) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  div_d = op_is_div(op);
                  neg_d = a_neg ^ b_neg;
                  cnt_d = CW'(WID - 1);
                  acc_d = '0;
                  if (op_is_div(op)) begin
                     lo_d    = a_abs;
                     opd_d   = b_abs;
                     state_d = ST_DIV;
`ifdef RTF65002_MULDIV_DIV_EN
                     rneg_d = a_neg;
                     dz_d   = (b == '0);
                     if (b == '0) lo_d = a;
`endif
                  end else begin
                     lo_d    = b_abs;
                     opd_d   = a_abs;
                     state_d = ST_MUL;
                  end
               end
            end
            ST_MUL: begin
               acc_d = {1'b0, sum[WID:1]};
               lo_d  = {sum[0], lo_q[WID-1:1]};
               if (cnt_q == '0) state_d = ST_FIXUP;
               else             cnt_d   = cnt_q - CW'(1);
            end
            ST_DIV: begin
`ifdef RTF65002_MULDIV_DIV_EN
               if (dz_q) begin
                  state_d = ST_FIXUP;
               end else begin
                  acc_d = {1'b0, drem};
                  lo_d  = dquo;
                  if (cnt_q == '0) state_d = ST_FIXUP;
                  else             cnt_d   = cnt_q - CW'(1);
               end
`else
               state_d = ST_FIXUP;
`endif
            end
            ST_FIXUP: begin
               state_d = ST_DONE;
               if (!div_q) begin
                  prod_d = neg_q ? -mul_res : mul_res;
                  quo_d  = prod_d[WID-1:0];
                  rem_d  = prod_d[2*WID-1:WID];
                  dbz_d  = 1'b0;
               end else begin
`ifdef RTF65002_MULDIV_DIV_EN
                  if (dz_q) begin
                     quo_d = '1;
                     rem_d = lo_q;
                     dbz_d = 1'b1;
                  end else begin
                     quo_d = neg_q  ? -lo_q : lo_q;
                     rem_d = rneg_q ? -acc_q[WID-1:0] : acc_q[WID-1:0];
                     dbz_d = 1'b0;
                  end
                  prod_d = {rem_d, quo_d};
`else
                  quo_d  = '0;
                  rem_d  = '0;
                  prod_d = '0;
                  dbz_d  = 1'b0;
`endif
               end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         lo_q    <= '0;
         opd_q   <= '0;
         neg_q   <= 1'b0;
         div_q   <= 1'b0;
         prod_q  <= '0;
         quo_q   <= '0;
         rem_q   <= '0;
         dbz_q   <= 1'b0;
`ifdef RTF65002_MULDIV_DIV_EN
         rneg_q  <= 1'b0;
         dz_q    <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         lo_q    <= lo_d;
         opd_q   <= opd_d;
         neg_q   <= neg_d;
         div_q   <= div_d;
         prod_q  <= prod_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         dbz_q   <= dbz_d;
`ifdef RTF65002_MULDIV_DIV_EN
         rneg_q  <= rneg_d;
         dz_q    <= dz_d;
`endif
      end
   end

   assign busy = (state_q != ST_IDLE);
   assign done = (state_q == ST_DONE);
   assign prod = prod_q;
   assign quo  = quo_q;
   assign rem  = rem_q;
   assign dbz  = dbz_q;

endmodule
